// File: rtl/sdspi_host_arbiter_pkg.sv
// rtl/sdspi_host_arbiter_pkg.sv - shared state encoding and defaults for the sdspi host arbiter
package sdspi_host_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam logic [31:0] DEFAULT_TIMEOUT = 32'hFFFFF;

    // Width of a requester index; at least one bit so N_REQ=1 style corner cases stay legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdspi_host_arbiter_rr_picker.sv
// rtl/sdspi_host_arbiter_rr_picker.sv - one-hot round-robin selector
// Ports:
//   req      requester request vector
//   ptr      index of the highest-priority requester this round
//   pick     one-hot selection (first set req at or after ptr, wrapping)
//   pick_idx binary index of pick
//   any      at least one request is set
module sdspi_host_arbiter_rr_picker
    import sdspi_host_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PW    = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PW-1:0]    pick_idx,
    output logic             any
);

    int idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!any && req[idx]) begin
                any       = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/sdspi_host_arbiter.sv
// rtl/sdspi_host_arbiter.sv - shares one sdspihost command port between N_REQ requesters
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req / gnt                     level requests in, registered one-hot grant out
//   rq_*                          per-requester commands in, busy/err out, broadcast read byte
//   spi_*                         host command lines out, host status in
//   timeout_evt                   one-cycle pulse when the watchdog forces a release
module sdspi_host_arbiter
    import sdspi_host_arbiter_pkg::*;
#(
    parameter int          N_REQ   = 2,
    parameter logic [31:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    output logic [N_REQ-1:0]      gnt,
    input  logic [N_REQ-1:0]      rq_r_block,
    input  logic [N_REQ-1:0]      rq_r_byte,
    input  logic [N_REQ-1:0]      rq_w_block,
    input  logic [N_REQ-1:0]      rq_w_byte,
    input  logic [N_REQ-1:0]      rq_spi_rst,
    input  logic [32*N_REQ-1:0]   rq_block_addr,
    input  logic [8*N_REQ-1:0]    rq_data_in,
    output logic [N_REQ-1:0]      rq_busy,
    output logic [7:0]            rq_data_out,
    output logic [N_REQ-1:0]      rq_err,
    output logic                  spi_r_block,
    output logic                  spi_r_byte,
    output logic                  spi_w_block,
    output logic                  spi_w_byte,
    output logic                  spi_rst,
    output logic [31:0]           spi_block_addr,
    output logic [7:0]            spi_data_in,
    input  logic                  spi_busy,
    input  logic                  spi_err,
    input  logic                  spi_crc_err,
    input  logic [7:0]            spi_data_out,
    output logic                  timeout_evt
);

    localparam int PW = ptr_width(N_REQ);

    arb_state_t        state;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     rr_ptr;
    logic [31:0]       hold_cnt;

    logic [N_REQ-1:0]  pick;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;

    sdspi_host_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_picker (
        .req      (req),
        .ptr      (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    logic          owner_req;
    logic          hold_expired;
    logic [PW-1:0] ptr_after_owner;

    assign owner_req       = req[owner];
    // hold_cnt counts completed GRANT cycles minus one, so this fires on the TIMEOUT-th cycle.
    assign hold_expired    = (TIMEOUT != 32'd0) && (hold_cnt >= TIMEOUT - 32'd1);
    assign ptr_after_owner = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A host still busy from self-init must not be handed to anyone.
                    if (pick_any && !spi_busy) begin
                        gnt      <= pick;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (hold_cnt != 32'hFFFF_FFFF) begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                    if (!owner_req) begin
                        state <= ST_DRAIN;
                    end else if (hold_expired) begin
                        state       <= ST_DRAIN;
                        timeout_evt <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Keep ownership until the host finishes so a transfer is never cut short.
                    if (!spi_busy) begin
                        gnt    <= '0;
                        rr_ptr <= ptr_after_owner;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        spi_r_block    = 1'b0;
        spi_r_byte     = 1'b0;
        spi_w_block    = 1'b0;
        spi_w_byte     = 1'b0;
        spi_rst        = 1'b0;
        spi_block_addr = '0;
        spi_data_in    = '0;
        rq_busy        = '1;
        rq_err         = '0;
        if (state == ST_GRANT) begin
            spi_r_block    = rq_r_block[owner];
            spi_r_byte     = rq_r_byte[owner];
            spi_w_block    = rq_w_block[owner];
            spi_w_byte     = rq_w_byte[owner];
            spi_rst        = rq_spi_rst[owner];
            spi_block_addr = rq_block_addr[32*int'(owner) +: 32];
            spi_data_in    = rq_data_in[8*int'(owner) +: 8];
            rq_busy[owner] = spi_busy;
            rq_err[owner]  = spi_err | spi_crc_err;
        end
        // Watchdog release resets the host for the single DRAIN cycle that follows.
        spi_rst = spi_rst | timeout_evt;
    end

    assign rq_data_out = spi_data_out;

endmodule
